// File: rtl/response_rx_if.sv
// Signal bundle between the xmodem sender control FSM (master) and response_rx (slave).
interface response_rx_if;
    logic       get_response;
    logic       rx;
    logic [7:0] data;
    logic       data_valid;
    logic       saw_ack;
    logic       saw_nak;
    logic       saw_c;
    logic       timed_out;
    logic       frame_err;
    logic       busy;

    modport master (
        output get_response, rx,
        input  data, data_valid, saw_ack, saw_nak, saw_c, timed_out, frame_err, busy
    );

    modport slave (
        input  get_response, rx,
        output data, data_valid, saw_ack, saw_nak, saw_c, timed_out, frame_err, busy
    );
endinterface

// File: rtl/response_rx.sv
// response_rx: waits for one response byte (start 0, 8 bits MSB first, stop 1, one bit per clk).
// Optional macro RX_SYNC_EN inserts a two-flop rx synchronizer ahead of the FSM.
module response_rx #(
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int CNT_W          = 21
) (
    input logic          clk,
    input logic          rst_n,
    response_rx_if.slave bus
);
    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_WAIT_START = 2'd1;
    localparam logic [1:0] ST_DATA       = 2'd2;
    localparam logic [1:0] ST_STOP       = 2'd3;

    localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]       CH_ACK     = 8'h06;
    localparam logic [7:0]       CH_NAK     = 8'h15;
    localparam logic [7:0]       CH_C       = 8'h43;

    logic [1:0]       state;
    logic [CNT_W-1:0] timer;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_q;
    logic [7:0]       data_q;
    logic             dv_q;
    logic             ack_q;
    logic             nak_q;
    logic             c_q;
    logic             to_q;
    logic             fe_q;
    logic             busy_q;
    logic             rx_s;

`ifdef RX_SYNC_EN
    logic rx_p0;
    logic rx_p1;

    // rx crosses in from another clock domain; idle-high reset avoids a false start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
        end else begin
            rx_p0 <= bus.rx;
            rx_p1 <= rx_p0;
        end
    end

    assign rx_s = rx_p1;
`else
    assign rx_s = bus.rx;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            timer   <= '0;
            bit_cnt <= '0;
            shift_q <= '0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            ack_q   <= 1'b0;
            nak_q   <= 1'b0;
            c_q     <= 1'b0;
            to_q    <= 1'b0;
            fe_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            dv_q  <= 1'b0;
            ack_q <= 1'b0;
            nak_q <= 1'b0;
            c_q   <= 1'b0;
            to_q  <= 1'b0;
            fe_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.get_response) begin
                        state  <= ST_WAIT_START;
                        timer  <= '0;
                        busy_q <= 1'b1;
                    end
                end
                ST_WAIT_START: begin
                    // start bit has priority over an expiring timer
                    if (!rx_s) begin
                        state   <= ST_DATA;
                        bit_cnt <= 3'd7;
                    end else if (timer == TIMER_LAST) begin
                        state  <= ST_IDLE;
                        to_q   <= 1'b1;
                        busy_q <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_DATA: begin
                    shift_q[bit_cnt] <= rx_s;
                    bit_cnt          <= bit_cnt - 1'b1;
                    if (bit_cnt == 3'd0) begin
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                    if (rx_s) begin
                        data_q <= shift_q;
                        dv_q   <= 1'b1;
                        ack_q  <= (shift_q == CH_ACK);
                        nak_q  <= (shift_q == CH_NAK);
                        c_q    <= (shift_q == CH_C);
                    end else begin
                        fe_q <= 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data       = data_q;
    assign bus.data_valid = dv_q;
    assign bus.saw_ack    = ack_q;
    assign bus.saw_nak    = nak_q;
    assign bus.saw_c      = c_q;
    assign bus.timed_out  = to_q;
    assign bus.frame_err  = fe_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_response_rx.sv
// Self-checking bench for response_rx (TIMEOUT_CYCLES=16); pulses are logged by cycle and
// compared against expectations derived from the framing and timeout rules.
module tb_response_rx;
`ifdef RX_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic [7:0] last_data = 8'h00;

    // pulse flags packed as {data_valid, saw_ack, saw_nak, saw_c, timed_out, frame_err}
    typedef struct {
        int         cyc;
        logic [5:0] f;
        logic [7:0] d;
    } ev_t;
    ev_t ev_q[$];

    response_rx_if bus();

    response_rx #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        ev_t e;
        e.cyc = cyc;
        e.f   = {bus.data_valid, bus.saw_ack, bus.saw_nak, bus.saw_c, bus.timed_out, bus.frame_err};
        e.d   = bus.data;
        if (e.f != 6'b0) ev_q.push_back(e);
    end

    function automatic logic [5:0] model_flags(input logic [7:0] b, input logic stop_ok);
        if (!stop_ok) return 6'b000001;
        return {1'b1, b == 8'h06, b == 8'h15, b == 8'h43, 1'b0, 1'b0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic arm();
        bus.get_response = 1'b1;
        tick();
        bus.get_response = 1'b0;
    endtask

    // line frame starts in the current cycle; returns with the line idle again
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        bus.rx = 1'b0;
        tick();
        for (int i = 7; i >= 0; i--) begin
            bus.rx = b[i];
            tick();
        end
        bus.rx = stop_bit;
        tick();
        bus.rx = 1'b1;
    endtask

    task automatic test_reset();
        bus.rx = 1'b1;
        bus.get_response = 1'b0;
        rst_n = 1'b0;
        idle(3);
        n_tests++;
        if (bus.data !== 8'h00) begin
            n_fail++; $display("FAIL reset_data: got %h want 00", bus.data);
        end
        n_tests++;
        if ({bus.data_valid, bus.saw_ack, bus.saw_nak, bus.saw_c, bus.timed_out, bus.frame_err, bus.busy} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {bus.data_valid, bus.saw_ack, bus.saw_nak, bus.saw_c, bus.timed_out, bus.frame_err, bus.busy});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_unarmed();
        ev_q.delete();
        send_byte(8'h06, 1'b1);
        idle(SL + 3);
        n_tests++;
        if (ev_q.size() != 0) begin
            n_fail++; $display("FAIL unarmed_events: got %0d want 0", ev_q.size());
        end
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL unarmed_busy: got %b want 0", bus.busy);
        end
    endtask

    task automatic test_ack();
        int t;
        ev_q.delete();
        arm();
        idle(1);
        t = cyc;
        send_byte(8'h06, 1'b1);
        idle(SL + 3);
        n_tests++;
        if (ev_q.size() != 1) begin
            n_fail++; $display("FAIL ack_events: got %0d want 1", ev_q.size());
        end else begin
            n_tests++;
            if (ev_q[0].cyc != t + 10 + SL) begin
                n_fail++; $display("FAIL ack_latency: got %0d want %0d", ev_q[0].cyc, t + 10 + SL);
            end
            n_tests++;
            if (ev_q[0].f !== 6'b110000) begin
                n_fail++; $display("FAIL ack_flags: got %b want 110000", ev_q[0].f);
            end
            n_tests++;
            if (ev_q[0].d !== 8'h06) begin
                n_fail++; $display("FAIL ack_data: got %h want 06", ev_q[0].d);
            end
        end
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL ack_busy: got %b want 0", bus.busy);
        end
        last_data = 8'h06;
    endtask

    task automatic test_back_to_back();
        logic [7:0] bs [3];
        int         ts [3];
        bs[0] = 8'h15; bs[1] = 8'h43; bs[2] = 8'hA5;
        ev_q.delete();
        for (int i = 0; i < 3; i++) begin
            arm();
            ts[i] = cyc;
            send_byte(bs[i], 1'b1);
            idle(SL);
            if (i < 2) begin
                n_tests++;
                if (bus.data_valid !== 1'b1) begin
                    n_fail++; $display("FAIL b2b_dv_at_rearm%0d: got %b want 1", i, bus.data_valid);
                end
            end
        end
        idle(3);
        n_tests++;
        if (ev_q.size() != 3) begin
            n_fail++; $display("FAIL b2b_events: got %0d want 3", ev_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (ev_q[i].cyc != ts[i] + 10 + SL || ev_q[i].f !== model_flags(bs[i], 1'b1) || ev_q[i].d !== bs[i]) begin
                    n_fail++;
                    $display("FAIL b2b_byte%0d: got cyc %0d flags %b data %h want cyc %0d flags %b data %h",
                             i, ev_q[i].cyc, ev_q[i].f, ev_q[i].d, ts[i] + 10 + SL, model_flags(bs[i], 1'b1), bs[i]);
                end
            end
        end
        last_data = 8'hA5;
    endtask

    task automatic test_timeout();
        int a;
        int t;
        ev_q.delete();
        a = cyc;
        arm();
        n_tests++;
        if (bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL to_busy_armed: got %b want 1", bus.busy);
        end
        idle(24);
        n_tests++;
        if (ev_q.size() != 1) begin
            n_fail++; $display("FAIL to_events: got %0d want 1", ev_q.size());
        end else begin
            n_tests++;
            if (ev_q[0].cyc != a + TO + 1 || ev_q[0].f !== 6'b000010) begin
                n_fail++; $display("FAIL to_pulse: got cyc %0d flags %b want cyc %0d flags 000010",
                                   ev_q[0].cyc, ev_q[0].f, a + TO + 1);
            end
        end
        n_tests++;
        if (bus.busy !== 1'b0 || bus.data !== last_data) begin
            n_fail++; $display("FAIL to_after: got busy %b data %h want busy 0 data %h", bus.busy, bus.data, last_data);
        end
        // start bit seen on the final timer cycle wins
        ev_q.delete();
        a = cyc;
        arm();
        idle(TO - 1 - SL);
        t = cyc;
        send_byte(8'h43, 1'b1);
        idle(SL + 3);
        n_tests++;
        if (ev_q.size() != 1 || ev_q[0].cyc != t + 10 + SL || ev_q[0].f !== 6'b100100) begin
            n_fail++; $display("FAIL to_last_cycle_start: got %0d events first flags %b want 1 event flags 100100",
                               ev_q.size(), (ev_q.size() > 0) ? ev_q[0].f : 6'b0);
        end
        last_data = 8'h43;
        // one cycle later is too late
        ev_q.delete();
        a = cyc;
        arm();
        idle(TO - SL);
        send_byte(8'h15, 1'b1);
        idle(SL + 3);
        n_tests++;
        if (ev_q.size() != 1 || ev_q[0].cyc != a + TO + 1 || ev_q[0].f !== 6'b000010) begin
            n_fail++; $display("FAIL to_late_start: got %0d events first flags %b want 1 event flags 000010",
                               ev_q.size(), (ev_q.size() > 0) ? ev_q[0].f : 6'b0);
        end
    endtask

    task automatic test_frame_err();
        int t;
        ev_q.delete();
        arm();
        t = cyc;
        send_byte(8'h06, 1'b0);
        idle(SL + 3);
        n_tests++;
        if (ev_q.size() != 1) begin
            n_fail++; $display("FAIL fe_events: got %0d want 1", ev_q.size());
        end else begin
            n_tests++;
            if (ev_q[0].cyc != t + 10 + SL || ev_q[0].f !== 6'b000001) begin
                n_fail++; $display("FAIL fe_pulse: got cyc %0d flags %b want cyc %0d flags 000001",
                                   ev_q[0].cyc, ev_q[0].f, t + 10 + SL);
            end
        end
        n_tests++;
        if (bus.data !== last_data) begin
            n_fail++; $display("FAIL fe_data_kept: got %h want %h", bus.data, last_data);
        end
    endtask

    task automatic test_busy_rearm();
        int         a;
        int         t;
        logic [7:0] b;
        ev_q.delete();
        a = cyc;
        arm();
        idle(7);
        arm();
        idle(20);
        n_tests++;
        if (ev_q.size() != 1 || ev_q[0].cyc != a + TO + 1 || ev_q[0].f !== 6'b000010) begin
            n_fail++; $display("FAIL rearm_timer: got %0d events first cyc %0d want 1 event cyc %0d",
                               ev_q.size(), (ev_q.size() > 0) ? ev_q[0].cyc : -1, a + TO + 1);
        end
        ev_q.delete();
        b = 8'h15;
        arm();
        t = cyc;
        bus.rx = 1'b0;
        tick();
        for (int i = 7; i >= 0; i--) begin
            bus.rx = b[i];
            bus.get_response = (i == 4);
            tick();
        end
        bus.get_response = 1'b0;
        bus.rx = 1'b1;
        tick();
        idle(SL + 3);
        n_tests++;
        if (ev_q.size() != 1 || ev_q[0].cyc != t + 10 + SL || ev_q[0].f !== 6'b101000 || ev_q[0].d !== b) begin
            n_fail++; $display("FAIL rearm_midbyte: got %0d events first flags %b data %h want 1 event flags 101000 data 15",
                               ev_q.size(), (ev_q.size() > 0) ? ev_q[0].f : 6'b0, (ev_q.size() > 0) ? ev_q[0].d : 8'h0);
        end
        last_data = b;
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        b = 8'h43;
        ev_q.delete();
        arm();
        bus.rx = 1'b0;
        tick();
        for (int i = 7; i >= 4; i--) begin
            bus.rx = b[i];
            tick();
        end
        bus.rx = b[3];
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.data, bus.data_valid, bus.saw_ack, bus.saw_nak, bus.saw_c, bus.timed_out, bus.frame_err, bus.busy} !== 15'h0) begin
            n_fail++; $display("FAIL rst_mid_immediate: got data %h busy %b want all zero", bus.data, bus.busy);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 2; i >= 0; i--) begin
            bus.rx = b[i];
            tick();
        end
        send_byte(8'h06, 1'b1);
        idle(SL + 3);
        n_tests++;
        if (ev_q.size() != 0 || bus.busy !== 1'b0 || bus.data !== 8'h00) begin
            n_fail++; $display("FAIL rst_mid_after: got %0d events busy %b data %h want 0 events busy 0 data 00",
                               ev_q.size(), bus.busy, bus.data);
        end
        last_data = 8'h00;
    endtask

    task automatic test_random();
        for (int it = 0; it < 24; it++) begin
            logic [7:0] b;
            logic       stop_ok;
            logic [5:0] ef;
            logic [7:0] ed;
            int         sel;
            int         g;
            int         a;
            int         t;
            int         ec;
            sel = int'($urandom_range(0, 4));
            b = (sel == 0) ? 8'h06 : (sel == 1) ? 8'h15 : (sel == 2) ? 8'h43 : 8'($urandom);
            stop_ok = ($urandom_range(0, 5) != 0);
            g = int'($urandom_range(0, 18));
            ev_q.delete();
            a = cyc;
            arm();
            idle(g);
            t = cyc;
            send_byte(b, stop_ok);
            if (t + SL <= a + TO) begin
                ec = t + 10 + SL;
                ef = model_flags(b, stop_ok);
                if (stop_ok) last_data = b;
            end else begin
                ec = a + TO + 1;
                ef = 6'b000010;
            end
            ed = last_data;
            idle(SL + 1 + int'($urandom_range(0, 2)));
            n_tests++;
            if (ev_q.size() != 1 || ev_q[0].cyc != ec || ev_q[0].f !== ef || ev_q[0].d !== ed) begin
                n_fail++;
                $display("FAIL rand%0d byte %h stop %b gap %0d: got %0d events cyc %0d flags %b data %h want cyc %0d flags %b data %h",
                         it, b, stop_ok, g, ev_q.size(), (ev_q.size() > 0) ? ev_q[0].cyc : -1,
                         (ev_q.size() > 0) ? ev_q[0].f : 6'b0, (ev_q.size() > 0) ? ev_q[0].d : 8'h0, ec, ef, ed);
            end
        end
    endtask

    initial begin
        bus.rx = 1'b1;
        bus.get_response = 1'b0;
        test_reset();
        test_unarmed();
        test_ack();
        test_back_to_back();
        test_timeout();
        test_frame_err();
        test_busy_rearm();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got time %0t want < 200000", $time);
        $fatal(1);
    end

endmodule

// File: doc/response_rx.md
Name: response_rx

Overview:
- Receive-side companion of the xmodem sender's byte transmitter; sits between the rx line from the xmodem receiver and the sender's control FSM.
- When armed by get_response, waits for one byte on rx, deserializes it, and flags it as ACK (0x06), NAK (0x15) or 'C' (0x43).
- Reports a timeout if no start bit arrives in time and a framing error if the stop bit is bad.
- Line framing matches our transmitter, one bit per clk: start bit 0, 8 data bits MSB first, stop bit 1, idle high.

Parameters:
TIMEOUT_CYCLES, 1048576, cycles spent waiting for a start bit before timed_out; minimum 2.
CNT_W, 21, width of the timeout counter; must hold TIMEOUT_CYCLES-1.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
get_response  input  1  arm request, single-cycle pulse, honoured only in IDLE
rx  input  1  serial line from the xmodem receiver, idle high
data  output  8  last correctly framed byte, held until the next one
data_valid  output  1  one-cycle pulse, data updated
saw_ack  output  1  one-cycle pulse with data_valid when data==0x06
saw_nak  output  1  one-cycle pulse with data_valid when data==0x15
saw_c  output  1  one-cycle pulse with data_valid when data==0x43
timed_out  output  1  one-cycle pulse, no start bit within TIMEOUT_CYCLES
frame_err  output  1  one-cycle pulse, stop bit sampled 0
busy  output  1  high in every state other than IDLE

Behaviour:
- One clock: clk. Reset is asynchronous, active-low: rst_n.
- Reset (async assert, sync deassert assumed upstream) sets:
  - state=IDLE; data=0x00; all pulse outputs 0; busy=0; counters 0.
- All outputs are registered. "Sampled rx" means rx itself, or its synchronized copy when RX_SYNC_EN is defined.
- FSM states: IDLE, WAIT_START, DATA, STOP.
- IDLE:
  - get_response=1 -> WAIT_START; timer cleared to 0.
  - rx is ignored in IDLE; a byte arriving unarmed is lost.
- WAIT_START:
  - sampled rx==0 -> DATA; bit_cnt=7.
  - Otherwise, if timer==TIMEOUT_CYCLES-1 -> IDLE and pulse timed_out next cycle.
  - Otherwise timer+1.
  - If a start bit and the timeout occur in the same cycle, the start bit wins; no timed_out.
- DATA:
  - Each cycle, shift sampled rx into shift register bit bit_cnt, then bit_cnt-1.
  - After bit 0 -> STOP. Exactly 8 cycles in DATA.
- STOP:
  - sampled rx==1 -> IDLE. Next cycle: data=shift register, data_valid=1, plus at most one of saw_ack/saw_nak/saw_c.
  - sampled rx==0 -> IDLE. frame_err=1 next cycle; data unchanged; data_valid=0.
- Latency: start bit sampled in cycle T; data bits in T+1..T+8; stop bit in T+9; data_valid high in T+10. busy drops in T+10.
- get_response while busy is ignored; it does not restart the timer.
- Back-to-back operation: get_response in the same cycle data_valid/timed_out/frame_err pulses is accepted, since the state is already IDLE.
- Reset asserted mid-byte aborts immediately, with no pulse and data unchanged from its reset value. After release, the block stays idle until the next get_response.
- Timer saturates logic-wise at TIMEOUT_CYCLES-1 and never wraps.
- Illegal state encodings go to IDLE.

Optional Feature:
RX_SYNC_EN:
- Defined: rx passes through a two-flop synchronizer, reset value 1, before the FSM.
  - Every rx-relative latency grows by 2 cycles (data_valid at T+12, measured from rx start edge at T).
  - The timeout window is unchanged, counted from arming.
- Undefined: rx is sampled directly, with latency as above. This is for use when rx comes from a same-clock transmitter.

Test Plan:
- Arm, then send 0x06 framed (0, bits MSB first, 1) two cycles later -> data_valid and saw_ack pulse together 10 cycles after the start bit; data=0x06; saw_nak=saw_c=0.
- Arm and send 0x15, then rearm in the data_valid cycle and send 0x43 -> saw_nak then saw_c; data ends 0x43. Then send 0xA5 -> data_valid only, no classification flag.
- TIMEOUT_CYCLES=16, arm, hold rx=1 -> timed_out pulses exactly once, 17 cycles after get_response; busy low afterwards. Repeat with the start bit on the final timer cycle -> byte received, no timed_out.
- Send 0x06 with stop bit 0 -> frame_err pulse; no data_valid; data keeps its previous value.
- Pulse get_response again mid-byte -> ignored; byte still decoded correctly.
- Drop rst_n at data bit 3 -> outputs 0 immediately, state IDLE.
- Build with RX_SYNC_EN: repeat the first scenario -> data_valid at start+12.
